i2c_eeprom_seq: RTL
===================

I2C_EEPROM_SEQ -- requirements
Module: i2c_eeprom_seq

Interface
REQ-001 Parameter DEV_ADDR, default 8'hA0: 7-bit EEPROM address in [7:1]; bit0 is overwritten per transaction.
REQ-002 Parameter START_ADDR, default 8'h00: first EEPROM word address.
REQ-003 Parameter NUM_BYTES, default 16, legal range 1..256: bytes written, then read back.
REQ-004 Parameter PAT_XOR, default 8'h5A: write data for word address a is a ^ PAT_XOR.
REQ-005 Parameter WR_WAIT_CYC, default 250000: idle clk cycles after each write, covering the EEPROM internal write time of 5 ms at 50 MHz.
REQ-006 Parameter TIMEOUT_CYC, default 1000000: maximum clk cycles from i2c_start to i2c_done.
REQ-007 clk  in  1  system clock (50 MHz).
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  single-cycle request to run one write/read-back pass.
REQ-010 i2c_config_data  out  24  {device_addr[7:0], word_addr[7:0], wr_data[7:0]} to the I2C controller.
REQ-011 i2c_start  out  1  single-cycle transaction request to the I2C controller.
REQ-012 i2c_done  in  1  single-cycle pulse from the controller when a transaction ends.
REQ-013 i2c_rd_data  in  8  read byte from the controller, valid in the i2c_done cycle of a read.
REQ-014 busy  out  1  high from the cycle after an accepted start until the done pulse.
REQ-015 done  out  1  single-cycle pulse at end of a pass.
REQ-016 pass  out  1  result of the last pass, held until the next accepted start.
REQ-017 err_cnt  out  8  number of read-back mismatches, saturating at 255.
REQ-018 err_addr  out  8  word address of the first mismatch; 8'h00 if there is none.
REQ-019 timeout  out  1  sticky for the pass; set when any transaction exceeds TIMEOUT_CYC.

Function
REQ-020 FSM states: IDLE, WR_REQ, WR_WAIT, WR_DELAY, RD_REQ, RD_WAIT, CHECK, FINISH.
REQ-021 IDLE->WR_REQ on start; on accept, clear idx, err_cnt, err_addr, pass and timeout; start SHALL be ignored in any other state.
REQ-022 WR_REQ: drive i2c_config_data = {DEV_ADDR&8'hFE, START_ADDR+idx, (START_ADDR+idx)^PAT_XOR}, pulse i2c_start for one cycle, then go to WR_WAIT.
REQ-023 i2c_config_data SHALL stay stable from the REQ cycle until the matching i2c_done cycle inclusive.
REQ-024 WR_WAIT: on i2c_done go to WR_DELAY; the delay counter loads WR_WAIT_CYC-1.
REQ-025 WR_DELAY: count down to 0, then go to WR_REQ with idx+1, or to RD_REQ with idx=0 if idx==NUM_BYTES-1.
REQ-026 RD_REQ: drive i2c_config_data = {DEV_ADDR|8'h01, START_ADDR+idx, 8'h00}, pulse i2c_start, then go to RD_WAIT.
REQ-027 RD_WAIT: on i2c_done, capture i2c_rd_data into a register and go to CHECK.
REQ-028 CHECK, one cycle: if captured != (START_ADDR+idx)^PAT_XOR, increment err_cnt (saturating) and set err_addr if this is the first error.
REQ-029 CHECK: then go to RD_REQ with idx+1, or to FINISH if idx==NUM_BYTES-1.
REQ-030 FINISH: pulse done, set pass = (err_cnt==0 && !timeout), return to IDLE; busy SHALL deassert in the same cycle as done.
REQ-031 Word address SHALL be computed mod 256; START_ADDR+idx wraps from 8'hFF to 8'h00. idx is 9 bits.
REQ-032 A timeout counter SHALL run in WR_WAIT/RD_WAIT. On reaching TIMEOUT_CYC: set timeout and go directly to FINISH, so pass=0.
REQ-033 i2c_done arriving outside WR_WAIT/RD_WAIT SHALL be ignored.
REQ-034 i2c_done in the same cycle as the timeout SHALL be treated as done; no timeout is recorded.
REQ-035 Latency from start to the first i2c_start SHALL be 2 cycles.

Reset
REQ-036 On rst_n low, the FSM SHALL go to IDLE asynchronously, mid-pass included.
REQ-037 On rst_n low: i2c_start=0, i2c_config_data=0, busy=0, done=0, pass=0, err_cnt=0, err_addr=0, timeout=0, and all counters=0.
REQ-038 After reset, no transaction SHALL be issued until a new start.

Structure
REQ-039 Shared package i2c_pkg SHALL hold the config field positions (DEV [23:16], ADDR [15:8], DATA [7:0]), the R/W bit index 16, and this FSM's state encoding.
REQ-040 One sub-module, i2c_seq_timer, SHALL provide the loadable down-counter, reused for WR_DELAY and the timeout.

Verification
REQ-041 NUM_BYTES=4, WR_WAIT_CYC=10, ideal EEPROM model -> writes to 0..3 carry data 5A,5B,58,59; 4 reads follow; done with pass=1, err_cnt=0.
REQ-042 Model corrupts the read at addr 2 (returns 00) -> err_cnt=1, err_addr=8'h02, pass=0.
REQ-043 START_ADDR=8'hFE, NUM_BYTES=4 -> addresses FE, FF, 00, 01 in that order.
REQ-044 i2c_done withheld, TIMEOUT_CYC=100 -> timeout=1, done pulses 100 cycles after i2c_start, pass=0.
REQ-045 start re-pulsed while busy, plus a spurious i2c_done in WR_DELAY -> no extra transaction and idx unchanged.
REQ-046 rst_n asserted during RD_WAIT -> all outputs 0 immediately; a new start runs a full clean pass.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the EEPROM write/read-back sequencer: config word
// field positions, the R/W bit and the sequencer state encoding.
package i2c_pkg;

    localparam int CFG_W        = 24;
    localparam int CFG_DEV_MSB  = 23;
    localparam int CFG_DEV_LSB  = 16;
    localparam int CFG_ADDR_MSB = 15;
    localparam int CFG_ADDR_LSB = 8;
    localparam int CFG_DATA_MSB = 7;
    localparam int CFG_DATA_LSB = 0;
    localparam int CFG_RW_BIT   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_WR_DELAY,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_FINISH
    } seq_state_t;

    function automatic logic [CFG_W-1:0] pack_cfg(input logic [7:0] dev,
                                                   input logic [7:0] addr,
                                                   input logic [7:0] data);
        logic [CFG_W-1:0] cfg;
        cfg = '0;
        cfg[CFG_DEV_MSB:CFG_DEV_LSB]   = dev;
        cfg[CFG_ADDR_MSB:CFG_ADDR_LSB] = addr;
        cfg[CFG_DATA_MSB:CFG_DATA_LSB] = data;
        return cfg;
    endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter that stops at zero; shared by the post-write delay
// and the per-transaction timeout.
module i2c_seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_eeprom_seq.sv
// EEPROM self-test sequencer: writes an address-derived pattern to NUM_BYTES
// locations through an external I2C controller, reads them back and compares.
module i2c_eeprom_seq #(
    parameter logic [7:0] DEV_ADDR    = 8'hA0,
    parameter logic [7:0] START_ADDR  = 8'h00,
    parameter int         NUM_BYTES   = 16,
    parameter logic [7:0] PAT_XOR     = 8'h5A,
    parameter int         WR_WAIT_CYC = 250000,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [23:0] i2c_config_data,
    output logic        i2c_start,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_rd_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [7:0]  err_addr,
    output logic        timeout
);
    import i2c_pkg::*;

    localparam logic [8:0]  LAST_IDX = 9'(NUM_BYTES - 1);
    localparam logic [31:0] WR_LOAD  = 32'(WR_WAIT_CYC - 1);
    localparam logic [31:0] TO_LOAD  = 32'(TIMEOUT_CYC - 1);

    seq_state_t  state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  rd_q, rd_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [7:0]  err_addr_q, err_addr_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        i2c_start_q, i2c_start_d;
    logic [23:0] cfg_q, cfg_d;

    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_en;
    logic        tmr_zero;

    logic [7:0]  word_addr;
    logic [7:0]  exp_data;

    // 8-bit add wraps FF -> 00 naturally
    assign word_addr = START_ADDR + idx_q[7:0];
    assign exp_data  = word_addr ^ PAT_XOR;

    i2c_seq_timer #(
        .W(32)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_d        = rd_q;
        err_cnt_d   = err_cnt_q;
        err_addr_d  = err_addr_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        i2c_start_d = 1'b0;
        cfg_d       = cfg_q;
        tmr_load    = 1'b0;
        tmr_val     = TO_LOAD;
        tmr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WR_REQ;
                    idx_d      = '0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_WR_REQ: begin
                cfg_d             = pack_cfg(DEV_ADDR, word_addr, exp_data);
                cfg_d[CFG_RW_BIT] = 1'b0;
                i2c_start_d       = 1'b1;
                tmr_load          = 1'b1;
                tmr_val           = TO_LOAD;
                state_d           = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                // done wins over a timeout expiring in the same cycle
                if (i2c_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = WR_LOAD;
                    state_d  = S_WR_DELAY;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_WR_DELAY: begin
                if (tmr_zero) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 9'd1;
                        state_d = S_WR_REQ;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_RD_REQ: begin
                cfg_d             = pack_cfg(DEV_ADDR, word_addr, 8'h00);
                cfg_d[CFG_RW_BIT] = 1'b1;
                i2c_start_d       = 1'b1;
                tmr_load          = 1'b1;
                tmr_val           = TO_LOAD;
                state_d           = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i2c_done) begin
                    rd_d    = i2c_rd_data;
                    state_d = S_CHECK;
                end else if (tmr_zero) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_CHECK: begin
                if (rd_q != exp_data) begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    if (err_cnt_q == 8'd0) begin
                        err_addr_d = word_addr;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 9'd1;
                    state_d = S_RD_REQ;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result flags are registered on entry so they coincide with the FINISH cycle
        if (state_d == S_FINISH) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            pass_d = (err_cnt_d == 8'd0) && !timeout_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rd_q        <= '0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            i2c_start_q <= 1'b0;
            cfg_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_q        <= rd_d;
            err_cnt_q   <= err_cnt_d;
            err_addr_q  <= err_addr_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            i2c_start_q <= i2c_start_d;
            cfg_q       <= cfg_d;
        end
    end

    assign i2c_config_data = cfg_q;
    assign i2c_start       = i2c_start_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign err_addr        = err_addr_q;
    assign timeout         = timeout_q;

endmodule
